// File: rtl/serial_word_comparator.sv
// serial_word_comparator
//   Multi-cycle unsigned magnitude comparator for two WIDTH-bit operands.
//   It walks both operands MSB-first in 2-bit digits through an external 2-bit
//   comparator and stops at the first deciding digit.
//
// Ports
//   clk, rst_n            : rising-edge clock, asynchronous active-low reset
//   start                 : compare request, honoured only in IDLE
//   op_a, op_b            : operands, captured when start is accepted
//   dig_a, dig_b          : current digit pair driven to the 2-bit comparator
//   cmp_lt/cmp_gt/cmp_eq  : flags returned by the 2-bit comparator
//   busy                  : high while RUN or DONE
//   done                  : single-cycle pulse when the result is valid
//   lt, gt, eq            : registered word-level result, held until next start
//   err                   : registered flag, comparator returned a non-one-hot set
module serial_word_comparator #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [1:0]       dig_a,
  output logic [1:0]       dig_b,
  input  logic             cmp_lt,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic             err
);

  localparam int unsigned N  = WIDTH / 2;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [CW-1:0]    r_cnt;
  logic             r_lt;
  logic             r_gt;
  logic             r_eq;
  logic             r_err;

  logic w_onehot;
  logic w_last;
  logic w_load;
  logic w_shift;
  logic w_clear_sh;
  logic w_set_lt;
  logic w_set_gt;
  logic w_set_eq;
  logic w_set_err;

  // Digits come straight off the shift-register tops: glitch-free, zero in
  // IDLE because the registers are cleared on the way out of DONE, and held
  // during DONE because nothing shifts there.
  assign dig_a = r_sh_a[WIDTH-1 -: 2];
  assign dig_b = r_sh_b[WIDTH-1 -: 2];

  assign lt  = r_lt;
  assign gt  = r_gt;
  assign eq  = r_eq;
  assign err = r_err;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_clear_sh  = 1'b0;
    w_set_lt    = 1'b0;
    w_set_gt    = 1'b0;
    w_set_eq    = 1'b0;
    w_set_err   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    case ({cmp_lt, cmp_gt, cmp_eq})
      3'b100, 3'b010, 3'b001: w_onehot = 1'b1;
      default:                w_onehot = 1'b0;
    endcase
    w_last = (r_cnt == CW'(N - 1));

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        // A malformed flag set overrides every other decision.
        if (!w_onehot) begin
          w_set_err   = 1'b1;
          w_state_nxt = S_DONE;
        end else if (cmp_gt) begin
          w_set_gt    = 1'b1;
          w_state_nxt = S_DONE;
        end else if (cmp_lt) begin
          w_set_lt    = 1'b1;
          w_state_nxt = S_DONE;
        end else if (w_last) begin
          w_set_eq    = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_shift = 1'b1;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_clear_sh  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sh_a  <= '0;
      r_sh_b  <= '0;
      r_cnt   <= '0;
      r_lt    <= 1'b0;
      r_gt    <= 1'b0;
      r_eq    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_load) begin
        r_sh_a <= op_a;
        r_sh_b <= op_b;
        r_cnt  <= '0;
      end else if (w_shift) begin
        r_sh_a <= r_sh_a << 2;
        r_sh_b <= r_sh_b << 2;
        r_cnt  <= r_cnt + CW'(1);
      end else if (w_clear_sh) begin
        r_sh_a <= '0;
        r_sh_b <= '0;
        r_cnt  <= '0;
      end

      if (w_load) begin
        r_lt  <= 1'b0;
        r_gt  <= 1'b0;
        r_eq  <= 1'b0;
        r_err <= 1'b0;
      end else begin
        if (w_set_lt)  r_lt  <= 1'b1;
        if (w_set_gt)  r_gt  <= 1'b1;
        if (w_set_eq)  r_eq  <= 1'b1;
        if (w_set_err) r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_comparator.sv
module tb_serial_word_comparator;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [1:0] dig_a;
  logic [1:0] dig_b;
  logic       cmp_lt;
  logic       cmp_gt;
  logic       cmp_eq;
  logic       busy;
  logic       done;
  logic       lt;
  logic       gt;
  logic       eq;
  logic       err;
  logic       fault_en;

  int unsigned n_pass;
  int unsigned n_total;

  serial_word_comparator #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .dig_a  (dig_a),
    .dig_b  (dig_b),
    .cmp_lt (cmp_lt),
    .cmp_gt (cmp_gt),
    .cmp_eq (cmp_eq),
    .busy   (busy),
    .done   (done),
    .lt     (lt),
    .gt     (gt),
    .eq     (eq),
    .err    (err)
  );

  // 2-bit comparator model; fault_en forces an all-zero flag set.
  assign cmp_lt = !fault_en && (dig_a < dig_b);
  assign cmp_gt = !fault_en && (dig_a > dig_b);
  assign cmp_eq = !fault_en && (dig_a == dig_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] digit_of(input logic [7:0] v, input int unsigned k);
    logic [7:0] s;
    s = v >> (6 - 2 * k);
    return s[1:0];
  endfunction

  // {lt, gt, eq, err}
  function automatic logic [7:0] res();
    return {4'b0, lt, gt, eq, err};
  endfunction

  // One full compare: start accepted at E0, decision expected at E(edges).
  task automatic run_cmp(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input int unsigned edges, input logic [3:0] exp_res);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy@E0"}, {7'b0, busy}, 8'd1);
    check({tag, " res_clr@E0"}, res(), 8'h00);
    for (int unsigned k = 0; k < edges; k++) begin
      check($sformatf("%s dig_a[%0d]", tag, k), {6'b0, dig_a}, {6'b0, digit_of(a, k)});
      check($sformatf("%s dig_b[%0d]", tag, k), {6'b0, dig_b}, {6'b0, digit_of(b, k)});
      tick();
      if (k + 1 < edges)
        check($sformatf("%s done_lo[%0d]", tag, k), {7'b0, done}, 8'd0);
    end
    check({tag, " done"}, {7'b0, done}, 8'd1);
    check({tag, " busy@done"}, {7'b0, busy}, 8'd1);
    check({tag, " result"}, res(), {4'b0, exp_res});
    tick();
    check({tag, " done_end"}, {7'b0, done}, 8'd0);
    check({tag, " busy_end"}, {7'b0, busy}, 8'd0);
    check({tag, " dig_idle"}, {4'b0, dig_a, dig_b}, 8'h00);
    check({tag, " hold"}, res(), {4'b0, exp_res});
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    op_a     = 8'h00;
    op_b     = 8'h00;
    fault_en = 1'b0;

    // Reset values before any clock edge.
    #1;
    check("rst busy", {7'b0, busy}, 8'd0);
    check("rst done", {7'b0, done}, 8'd0);
    check("rst res", res(), 8'h00);
    check("rst dig", {4'b0, dig_a, dig_b}, 8'h00);
    #3;
    rst_n = 1'b1;
    tick();

    // Equal words: all four digits consumed.
    run_cmp("eqA5", 8'hA5, 8'hA5, 4, 4'b0010);
    // MSB decides gt.
    run_cmp("gtC0", 8'hC0, 8'h40, 1, 4'b0100);
    // Last digit decides lt.
    run_cmp("lt12", 8'h12, 8'h13, 4, 4'b1000);

    // Start pulsed during RUN and DONE is ignored.
    op_a  = 8'hFF;
    op_b  = 8'h00;
    start = 1'b1;
    tick();                        // E0: accepted
    check("ign busy@E0", {7'b0, busy}, 8'd1);
    tick();                        // E1: decides, start still high in RUN
    check("ign done", {7'b0, done}, 8'd1);
    check("ign result", res(), 8'h04);
    tick();                        // E2: DONE -> IDLE, start high in DONE
    start = 1'b0;
    check("ign done_end", {7'b0, done}, 8'd0);
    check("ign busy_end", {7'b0, busy}, 8'd0);
    tick();
    check("ign no_retrig", {7'b0, busy}, 8'd0);
    check("ign hold", res(), 8'h04);

    // Faulty comparator on digit 2 (sampled at E3).
    op_a  = 8'h00;
    op_b  = 8'h00;
    start = 1'b1;
    tick();                        // E0
    start = 1'b0;
    tick();                        // E1
    tick();                        // E2
    check("flt pre_done", {7'b0, done}, 8'd0);
    fault_en = 1'b1;
    tick();                        // E3
    fault_en = 1'b0;
    check("flt done", {7'b0, done}, 8'd1);
    check("flt result", res(), 8'h01);
    tick();
    check("flt done_end", {7'b0, done}, 8'd0);
    check("flt hold", res(), 8'h01);

    // Reset during RUN discards the compare.
    op_a  = 8'h01;
    op_b  = 8'h02;
    start = 1'b1;
    tick();                        // E0
    start = 1'b0;
    check("mrst err_clr", res(), 8'h00);
    tick();                        // E1
    tick();                        // E2
    check("mrst busy_run", {7'b0, busy}, 8'd1);
    rst_n = 1'b0;
    #1;
    check("mrst busy", {7'b0, busy}, 8'd0);
    check("mrst done", {7'b0, done}, 8'd0);
    check("mrst res", res(), 8'h00);
    check("mrst dig", {4'b0, dig_a, dig_b}, 8'h00);
    tick();
    tick();
    check("mrst no_done", {7'b0, done}, 8'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("mrst idle_done", {7'b0, done}, 8'd0);
    check("mrst idle_busy", {7'b0, busy}, 8'd0);

    // Back-to-back with start held; operand change after acceptance is ignored.
    op_a  = 8'hC0;
    op_b  = 8'h40;
    start = 1'b1;
    tick();                        // E0: accept C0/40
    op_a = 8'h12;
    op_b = 8'h13;
    tick();                        // E1: gt decided on latched operands
    check("b2b first_done", {7'b0, done}, 8'd1);
    check("b2b first_res", res(), 8'h04);
    tick();                        // E2: back to IDLE
    check("b2b idle", {7'b0, busy}, 8'd0);
    tick();                        // E3: re-trigger with 12/13
    start = 1'b0;
    check("b2b busy2", {7'b0, busy}, 8'd1);
    check("b2b res_clr", res(), 8'h00);
    tick();                        // E4
    tick();                        // E5
    tick();                        // E6
    check("b2b done_lo", {7'b0, done}, 8'd0);
    tick();                        // E7: last digit decides lt
    check("b2b second_done", {7'b0, done}, 8'd1);
    check("b2b second_res", res(), 8'h08);
    tick();
    check("b2b end", {7'b0, done}, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_word_comparator.md
Name: serial_word_comparator

Overview:
- Multi-cycle magnitude comparator for two WIDTH-bit unsigned operands.
- Drives 2-bit digit pairs, MSB first, into the team's 2-bit LUT comparator (a, b → lt, gt, eq).
- Consumes that comparator's flags and accumulates a word-level lt/gt/eq result.
- Sits directly upstream and downstream of the 2-bit comparator: it feeds the a/b inputs and reads back the flags in the same cycle.

Parameters:
- WIDTH, 8, operand width in bits; must be even and ≥2. Digit count is N = WIDTH/2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a compare; sampled only in IDLE
- op_a  in  WIDTH  operand A, latched when start is accepted
- op_b  in  WIDTH  operand B, latched when start is accepted
- dig_a  out  2  current A digit to the 2-bit comparator's a input
- dig_b  out  2  current B digit to the 2-bit comparator's b input
- cmp_lt  in  1  lt flag from the 2-bit comparator (combinational from dig_a/dig_b)
- cmp_gt  in  1  gt flag from the 2-bit comparator
- cmp_eq  in  1  eq flag from the 2-bit comparator
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse when the result becomes valid
- lt  out  1  registered result A<B
- gt  out  1  registered result A>B
- eq  out  1  registered result A==B
- err  out  1  registered flag: the comparator returned a non-one-hot flag set

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, shift registers=0, digit counter=0.
  - busy, done, lt, gt, eq, err all 0; dig_a=dig_b=0.
  - Applies immediately, including mid-RUN; the in-flight compare is discarded with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - dig_a=dig_b=0; busy=0.
  - start=1 at an edge: latch op_a/op_b into shift registers, clear lt/gt/eq/err, counter=0, go to RUN.
- RUN:
  - dig_a/dig_b are the top 2 bits of the shift registers, driven from registers (glitch-free).
  - cmp_* are sampled at each edge.
  - cmp_gt=1 (one-hot): gt←1, go to DONE.
  - cmp_lt=1 (one-hot): lt←1, go to DONE.
  - cmp_eq=1 and counter=N-1: eq←1, go to DONE.
  - cmp_eq=1 and counter<N-1: shift both registers left by 2, counter++, stay in RUN.
  - Flags not one-hot (000, or more than one set): err←1, lt/gt/eq stay 0, go to DONE. Error takes priority over all other decisions.
- DONE:
  - Lasts exactly one cycle; done=1, busy=1; dig_a/dig_b hold their last values.
  - Always returns to IDLE at the next edge.
- Latency:
  - The start edge is E0; digit k (0=MSB) is sampled at E(k+1).
  - done is high in the cycle after E(k+1), where k is the deciding digit. Minimum 1 edge, maximum N edges after E0.
- Result hold: lt/gt/eq/err stay stable after done until the next accepted start clears them.
- start while busy (RUN or DONE) is ignored; no queuing. start held high re-triggers in the first IDLE cycle after DONE.
- op_a/op_b changes after acceptance have no effect on the in-flight compare.
- Exactly one of lt/gt/eq/err is 1 after every completed compare.

Test Plan:
- Reset check: assert rst_n=0 → all outputs 0, dig_a=dig_b=0 immediately (before any clock edge).
- op_a=8'hA5, op_b=8'hA5, start pulse → dig pairs 2/2,2/2,1/1,1/1 at E1..E4; done in cycle after E4; eq=1, lt=gt=err=0.
- op_a=8'hC0, op_b=8'h40 → MSB digits 3 vs 1; done in cycle after E1; gt=1.
- op_a=8'h12, op_b=8'h13 → first three pairs equal, last pair 2 vs 3; done after E4; lt=1.
- Start 8'hFF vs 8'h00, then pulse start again during RUN and DONE → second start ignored; single done; gt=1.
- Faulty comparator model returns 3'b000 on digit 2 of 8'h00 vs 8'h00 → err=1, lt/gt/eq=0, done after E3.
- Reset mid-RUN: start 8'h01 vs 8'h02, assert rst_n=0 after E2 → no done pulse, outputs cleared.
- Back-to-back: start held high → second compare accepted in the first IDLE cycle after DONE; its results match the new operands.
